tag_packetizer: RTL and testbench

TAG_PACKETIZER -- requirements
Module: tag_packetizer

---
 rtl/tag_packetizer_if.sv | 24 ++
 rtl/tag_packetizer.sv | 121 ++++++++++++
 tb/tb_tag_packetizer.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tag_packetizer_if.sv
`default_nettype none
// ============================================================================
// Module      : tag_packetizer_if
// Description : Byte-FIFO write port carrying tag_packetizer packets.
// Revision    : 1.0 - initial release
// ============================================================================
interface tag_packetizer_if;
    logic [7:0] fifo_data;
    logic       fifo_wr_en;
    logic       fifo_full;

    modport master (
        output fifo_data,
        output fifo_wr_en,
        input  fifo_full
    );

    modport slave (
        input  fifo_data,
        input  fifo_wr_en,
        output fifo_full
    );
endinterface
`default_nettype wire

// File: rtl/tag_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : tag_packetizer
// Description : Timestamps rising edges on event channels and emits 4-byte
//               packets into a byte FIFO, counting events lost while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module tag_packetizer #(
    parameter int NCH    = 4,
    parameter int DROP_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              en,
    input  wire logic [NCH-1:0]    ch_in,
    input  wire logic              clr_drop,
    tag_packetizer_if.master       fifo,
    output logic                   busy,
    output logic [DROP_W-1:0]      drop_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_B0   = 3'd1,
        S_B1   = 3'd2,
        S_B2   = 3'd3,
        S_B3   = 3'd4
    } state_t;

    localparam logic [23:0]       c_TS_ONE   = 24'd1;
    localparam logic [DROP_W-1:0] c_DROP_ONE = DROP_W'(1);

    state_t            r_state;
    logic [23:0]       r_ts;
    logic [NCH-1:0]    r_ch_prev;
    logic [NCH-1:0]    r_mask;
    logic [23:0]       r_stamp;
    logic              r_pend;
    logic              r_drop_pend;
    logic [DROP_W-1:0] r_drop_count;

    logic [NCH-1:0]    w_ev;
    logic              w_event;
    logic              w_wr;
    logic              w_capture;
    logic              w_drop;
    logic [5:0]        w_mask6;
    logic [7:0]        w_byte;

    assign w_ev      = ch_in & ~r_ch_prev;
    assign w_event   = en && (w_ev != '0);
    assign w_wr      = (r_state != S_IDLE) && !fifo.fifo_full;
    // A B3 write frees the slot in the same cycle, allowing gapless packets.
    assign w_capture = w_event && ((r_state == S_IDLE) || ((r_state == S_B3) && w_wr));
    assign w_drop    = w_event && !w_capture;
    assign w_mask6   = 6'(r_mask);

    always_comb begin
        w_byte = 8'h00;
        case (r_state)
            S_B0:    w_byte = {1'b1, r_pend, w_mask6};
            S_B1:    w_byte = r_stamp[23:16];
            S_B2:    w_byte = r_stamp[15:8];
            S_B3:    w_byte = r_stamp[7:0];
            default: w_byte = 8'h00;
        endcase
    end

    assign fifo.fifo_data  = w_byte;
    assign fifo.fifo_wr_en = w_wr;
    assign busy            = (r_state != S_IDLE);
    assign drop_count      = r_drop_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_ts         <= '0;
            r_ch_prev    <= '0;
            r_mask       <= '0;
            r_stamp      <= '0;
            r_pend       <= 1'b0;
            r_drop_pend  <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_ch_prev <= ch_in;
            if (en) begin
                r_ts <= r_ts + c_TS_ONE;
            end

            case (r_state)
                S_IDLE:  if (w_capture) r_state <= S_B0;
                S_B0:    if (w_wr) r_state <= S_B1;
                S_B1:    if (w_wr) r_state <= S_B2;
                S_B2:    if (w_wr) r_state <= S_B3;
                S_B3:    if (w_wr) r_state <= w_capture ? S_B0 : S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            if (w_capture) begin
                r_mask  <= w_ev;
                r_stamp <= r_ts;
                r_pend  <= r_drop_pend;
            end

            // A drop wins over a capture clearing the pending flag.
            if (w_drop) begin
                r_drop_pend <= 1'b1;
            end else if (w_capture) begin
                r_drop_pend <= 1'b0;
            end

            if (clr_drop) begin
                r_drop_count <= w_drop ? c_DROP_ONE : '0;
            end else if (w_drop && !(&r_drop_count)) begin
                r_drop_count <= r_drop_count + c_DROP_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tag_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tag_packetizer
// Description : Randomised and directed bench for tag_packetizer against a
//               queue-based packet model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tag_packetizer;
    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           en = 1'b0;
    logic           clr_drop = 1'b0;
    logic [NCH-1:0] ch_in = '0;
    logic           busy;
    logic [7:0]     drop_count;
    logic [17:0]    obs;

    tag_packetizer_if fifo_if();

    tag_packetizer #(.NCH(NCH), .DROP_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ch_in      (ch_in),
        .clr_drop   (clr_drop),
        .fifo       (fifo_if),
        .busy       (busy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    assign obs = {fifo_if.fifo_wr_en, fifo_if.fifo_data, busy, drop_count};

    // Reference model: a packet is just a queue of bytes still to be sent.
    logic [7:0]     m_q[$];
    logic [23:0]    m_ts;
    logic [NCH-1:0] m_prev;
    logic           m_pend;
    int             m_drop;
    int             n_checks = 0;
    int             n_pass = 0;

    function automatic logic [17:0] model_out();
        logic       have;
        logic [7:0] d;
        have = (m_q.size() != 0);
        d    = have ? m_q[0] : 8'h00;
        return {have && !fifo_if.fifo_full, d, have, 8'(m_drop)};
    endfunction

    task automatic m_clear();
        m_q.delete();
        m_ts   = '0;
        m_prev = '0;
        m_pend = 1'b0;
        m_drop = 0;
    endtask

    task automatic m_step();
        logic [NCH-1:0] ev;
        logic           evt, wr, cap, drp;
        int             sz;
        ev  = ch_in & ~m_prev;
        evt = en && (ev != '0);
        sz  = m_q.size();
        wr  = (sz != 0) && !fifo_if.fifo_full;
        if (wr) void'(m_q.pop_front());
        cap = evt && ((sz == 0) || (sz == 1 && wr));
        drp = evt && !cap;
        if (cap) begin
            m_q.push_back(8'h80 | (m_pend ? 8'h40 : 8'h00) | 8'(ev));
            m_q.push_back(m_ts[23:16]);
            m_q.push_back(m_ts[15:8]);
            m_q.push_back(m_ts[7:0]);
            m_pend = 1'b0;
        end
        if (drp) m_pend = 1'b1;
        if (clr_drop) m_drop = drp ? 1 : 0;
        else if (drp && m_drop < 255) m_drop++;
        if (en) m_ts = m_ts + 24'd1;
        m_prev = ch_in;
    endtask

    task automatic cycle();
        m_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [NCH-1:0] ch);
        @(negedge clk);
        rst = 1'b0;
        ch_in = ch;
        en = 1'b0;
        clr_drop = 1'b0;
        fifo_if.fifo_full = 1'b0;
        m_clear();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset('0);
        rst = 1'b0;
        #1;
        n_checks++;
        if (obs !== 18'h0) $display("FAIL reset_held: got %h expected %h", obs, 18'h0);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== model_out()) $display("FAIL reset_release: got %h expected %h", obs, model_out());
        else n_pass++;
    endtask

    task automatic test_single_event();
        logic [7:0] got[$];
        logic [7:0] exp_b[4];
        int nb;
        exp_b = '{8'h84, 8'h00, 8'hAB, 8'hCD};
        nb = 0;
        do_reset('0);
        en = 1'b1;
        while (m_ts != 24'h00ABCD) cycle();
        ch_in = 4'b0100;
        cycle();
        for (int k = 0; k < 6; k++) begin
            #1;
            if (busy) nb++;
            if (fifo_if.fifo_wr_en) got.push_back(fifo_if.fifo_data);
            n_checks++;
            if (obs !== model_out()) $display("FAIL single_cyc%0d: got %h expected %h", k, obs, model_out());
            else n_pass++;
            cycle();
        end
        n_checks++;
        if (got.size() != 4) $display("FAIL single_count: got %0d expected %0d", got.size(), 4);
        else begin
            n_pass++;
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (got[i] !== exp_b[i]) $display("FAIL single_byte%0d: got %h expected %h", i, got[i], exp_b[i]);
                else n_pass++;
            end
        end
        n_checks++;
        if (nb != 4) $display("FAIL single_busy: got %0d expected %0d", nb, 4);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [7:0] got[$];
        logic [7:0] held;
        int nb;
        nb = 0;
        held = 8'h00;
        do_reset('0);
        en = 1'b1;
        repeat (5) cycle();
        ch_in = 4'b0001;
        cycle();
        for (int k = 0; k < 10; k++) begin
            fifo_if.fifo_full = (k >= 1 && k <= 3);
            #1;
            if (busy) nb++;
            if (fifo_if.fifo_wr_en) got.push_back(fifo_if.fifo_data);
            if (k == 1) held = fifo_if.fifo_data;
            if (k >= 1 && k <= 3) begin
                n_checks++;
                if (fifo_if.fifo_wr_en !== 1'b0 || fifo_if.fifo_data !== held)
                    $display("FAIL stall_hold%0d: got wr=%b data=%h expected wr=0 data=%h",
                             k, fifo_if.fifo_wr_en, fifo_if.fifo_data, held);
                else n_pass++;
            end
            n_checks++;
            if (obs !== model_out()) $display("FAIL stall_cyc%0d: got %h expected %h", k, obs, model_out());
            else n_pass++;
            cycle();
        end
        fifo_if.fifo_full = 1'b0;
        n_checks++;
        if (got.size() != 4 || got[0] !== 8'h81 || got[1] !== 8'h00 || got[2] !== 8'h00 || got[3] !== 8'h05)
            $display("FAIL stall_bytes: got %0d bytes first %h expected 81 00 00 05", got.size(),
                     (got.size() != 0) ? got[0] : 8'h00);
        else n_pass++;
        n_checks++;
        if (nb != 7) $display("FAIL stall_busy: got %0d expected %0d", nb, 7);
        else n_pass++;
    endtask

    task automatic test_drop();
        logic [7:0] got[$];
        logic [3:0] script[18];
        script = '{4'd1, 4'd1, 4'd3, 4'd3, 4'd3, 4'd0, 4'd4, 4'd4, 4'd4,
                   4'd4, 4'd4, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
        do_reset('0);
        en = 1'b1;
        repeat (3) cycle();
        for (int j = 0; j < 18; j++) begin
            ch_in = script[j];
            #1;
            if (fifo_if.fifo_wr_en) got.push_back(fifo_if.fifo_data);
            n_checks++;
            if (obs !== model_out()) $display("FAIL drop_cyc%0d: got %h expected %h", j, obs, model_out());
            else n_pass++;
            cycle();
            if (j == 2) begin
                n_checks++;
                if (drop_count !== 8'd1) $display("FAIL drop_count: got %0d expected %0d", drop_count, 1);
                else n_pass++;
            end
        end
        n_checks++;
        if (got.size() != 12) $display("FAIL drop_bytes: got %0d expected %0d", got.size(), 12);
        else begin
            n_pass++;
            n_checks++;
            if (got[4] !== 8'hC4) $display("FAIL drop_pend_set: got %h expected %h", got[4], 8'hC4);
            else n_pass++;
            n_checks++;
            if (got[8] !== 8'h81) $display("FAIL drop_pend_clr: got %h expected %h", got[8], 8'h81);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] script[10];
        int nwr;
        script = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3};
        nwr = 0;
        do_reset('0);
        en = 1'b1;
        for (int j = 0; j < 10; j++) begin
            ch_in = script[j];
            #1;
            if (fifo_if.fifo_wr_en) nwr++;
            if (j >= 1 && j <= 8) begin
                n_checks++;
                if (fifo_if.fifo_wr_en !== 1'b1) $display("FAIL b2b_gap%0d: got wr=%b expected wr=1", j, fifo_if.fifo_wr_en);
                else n_pass++;
            end
            if (j == 5) begin
                n_checks++;
                if (fifo_if.fifo_data !== 8'h82 || drop_count !== 8'd0)
                    $display("FAIL b2b_b0: got data=%h drop=%0d expected data=82 drop=0",
                             fifo_if.fifo_data, drop_count);
                else n_pass++;
            end
            n_checks++;
            if (obs !== model_out()) $display("FAIL b2b_cyc%0d: got %h expected %h", j, obs, model_out());
            else n_pass++;
            cycle();
        end
        n_checks++;
        if (nwr != 8) $display("FAIL b2b_writes: got %0d expected %0d", nwr, 8);
        else n_pass++;
    endtask

    task automatic test_saturate();
        do_reset('0);
        en = 1'b1;
        fifo_if.fifo_full = 1'b1;
        ch_in = 4'b0001;
        cycle();
        for (int i = 0; i < 600; i++) begin
            ch_in = (i % 2 == 1) ? 4'b0011 : 4'b0001;
            cycle();
        end
        #1;
        n_checks++;
        if (drop_count !== 8'd255) $display("FAIL sat_count: got %0d expected %0d", drop_count, 255);
        else n_pass++;
        ch_in = 4'b0001;
        cycle();
        ch_in = 4'b0011;
        clr_drop = 1'b1;
        cycle();
        #1;
        n_checks++;
        if (drop_count !== 8'd1) $display("FAIL clr_with_drop: got %0d expected %0d", drop_count, 1);
        else n_pass++;
        cycle();
        clr_drop = 1'b0;
        #1;
        n_checks++;
        if (drop_count !== 8'd0) $display("FAIL clr_alone: got %0d expected %0d", drop_count, 0);
        else n_pass++;
        fifo_if.fifo_full = 1'b0;
        repeat (6) cycle();
    endtask

    task automatic test_reset_mid_packet();
        do_reset('0);
        en = 1'b1;
        ch_in = 4'b0001;
        repeat (3) cycle();
        #1;
        n_checks++;
        if (obs !== model_out()) $display("FAIL midrst_b2: got %h expected %h", obs, model_out());
        else n_pass++;
        rst = 1'b0;
        ch_in = 4'b0010;
        #1;
        n_checks++;
        if (obs !== 18'h0) $display("FAIL midrst_async: got %h expected %h", obs, 18'h0);
        else n_pass++;
        m_clear();
        @(negedge clk);
        rst = 1'b1;
        cycle();
        #1;
        n_checks++;
        if (fifo_if.fifo_wr_en !== 1'b1 || fifo_if.fifo_data !== 8'h82)
            $display("FAIL midrst_fresh: got wr=%b data=%h expected wr=1 data=82",
                     fifo_if.fifo_wr_en, fifo_if.fifo_data);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++;
            if (obs !== model_out()) $display("FAIL midrst_cyc%0d: got %h expected %h", k, obs, model_out());
            else n_pass++;
            cycle();
        end
    endtask

    task automatic test_random();
        do_reset('0);
        for (int c = 0; c < 3000; c++) begin
            en = ($urandom % 8) != 0;
            ch_in = NCH'($urandom);
            fifo_if.fifo_full = ($urandom % 4) == 0;
            clr_drop = ($urandom % 60) == 0;
            #1;
            n_checks++;
            if (obs !== model_out()) $display("FAIL rand_cyc%0d: got %h expected %h", c, obs, model_out());
            else n_pass++;
            cycle();
        end
        clr_drop = 1'b0;
        fifo_if.fifo_full = 1'b0;
    endtask

    initial begin
        fifo_if.fifo_full = 1'b0;
        m_clear();
        test_reset();
        test_single_event();
        test_stall();
        test_drop();
        test_back_to_back();
        test_saturate();
        test_reset_mid_packet();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
